alu: RTL and testbench

Multi-cycle 8-bit unsigned arithmetic unit: ADD, SUB, MUL and DIV on two operands packed into one 16-bit input word. The block accepts one operation per valid/ready transaction, computes it (ADD/SUB in one cycle, MUL/DIV iteratively), and holds the registered result with `ready` until the next operation is accepted. It serves as the datapath arithmetic engine behind a simple request/complete handshake.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv.sv | 96 +++++++++
 rtl/alu.sv | 81 ++++++++
 tb/tb_alu.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and constants for the alu slice
package alu_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DIV0_RESULT = 8'hFF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single-cycle results: ADD, SUB, and the divide-by-zero shortcut.
  function automatic logic [DATA_W-1:0] alu_fast(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = DIV0_RESULT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier and restoring divider
// Eight iterations after start; done pulses for one cycle with the result stable.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  logic              busy_q, busy_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic [2:0]        step_q, step_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       mcand_q, mcand_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [DATA_W-1:0] div_q, div_d;
  logic [8:0]        rem_sh;
  logic [8:0]        rem_sub;

  always_comb begin
    busy_d  = busy_q;
    mode_d  = mode_q;
    step_d  = step_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    div_d   = div_q;
    done_d  = 1'b0;
    // Divide: mplr_q shifts the dividend out at the top and the quotient in at the bottom.
    rem_sh  = {acc_q[7:0], mplr_q[7]};
    rem_sub = rem_sh - {1'b0, div_q};
    if (start_i) begin
      busy_d  = 1'b1;
      mode_d  = mode_i;
      step_d  = 3'd0;
      acc_d   = 16'h0000;
      mcand_d = {8'h00, a_i};
      mplr_d  = mode_i ? a_i : b_i;
      div_d   = b_i;
    end else if (busy_q) begin
      if (mode_q) begin
        if (rem_sh >= {1'b0, div_q}) begin
          acc_d  = {8'h00, rem_sub[7:0]};
          mplr_d = {mplr_q[6:0], 1'b1};
        end else begin
          acc_d  = {8'h00, rem_sh[7:0]};
          mplr_d = {mplr_q[6:0], 1'b0};
        end
      end else begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
      end
      step_d = step_q + 3'd1;
      if (step_q == 3'd7) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 3'd0;
      acc_q   <= 16'h0000;
      mcand_q <= 16'h0000;
      mplr_q  <= '0;
      div_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      div_q   <= div_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = mode_q ? mplr_q : acc_q[7:0];

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit multi-cycle ALU with valid/ready handshake
// Fast ops spend one BUSY cycle; MUL/DIV wait in BUSY for the iterative unit.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in,
  input  logic [1:0]        op_codes,
  input  logic              valid,
  output logic [DATA_W-1:0] o,
  output logic              ready
);

  state_t            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] o_q;
  logic              ready_q;

  logic              accept;
  logic              md_start;
  logic              fast_op;
  logic              md_done;
  logic [DATA_W-1:0] md_result;

  assign accept   = valid && (state_q != BUSY);
  assign md_start = accept && op_codes[1] && !((op_codes == OP_DIV) && (in[7:0] == 8'h00));
  assign fast_op  = !op_q[1] || ((op_q == OP_DIV) && (b_q == 8'h00));

  alu_muldiv u_muldiv (
    .clk      (clk),
    .rst_n    (rst),
    .start_i  (md_start),
    .mode_i   (op_codes[0]),
    .a_i      (in[15:8]),
    .b_i      (in[7:0]),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      o_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (valid) begin
            a_q     <= in[15:8];
            b_q     <= in[7:0];
            op_q    <= op_codes;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (fast_op) begin
            o_q     <= alu_fast(op_q, a_q, b_q);
            ready_q <= 1'b1;
            state_q <= DONE;
          end else if (md_done) begin
            o_q     <= md_result;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o     = o_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: vector table, random model check, handshake corners
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_w = 16'h0000;
  logic [1:0]  op_w = 2'b00;
  logic        valid = 1'b0;
  logic [7:0]  o;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in_w),
    .op_codes (op_w),
    .valid    (valid),
    .o        (o),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    int         exp_o;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  function automatic int ref_o(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return (a * b) % 256;
      default: return (b == 0) ? 255 : a / b;
    endcase
  endfunction

  function automatic int ref_lat(input int b, input int op);
    if (op < 2 || (op == 3 && b == 0)) return 1;
    return 9;
  endfunction

  // Latency counts edges after the accept edge until ready is seen high.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output int lat, output int res);
    @(negedge clk);
    in_w  = {a, b};
    op_w  = op;
    valid = 1'b1;
    @(posedge clk);
    #1;
    check("ready_drop_on_accept", int'(ready), 0);
    @(negedge clk);
    valid = 1'b0;
    in_w  = 16'($urandom);
    op_w  = 2'($urandom);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (ready) lat = i;
    end
    res = int'(o);
  endtask

  int lat, res;

  initial begin
    vecs[0] = '{8'd25,  8'd17, OP_ADD, 42,  1};
    vecs[1] = '{8'd200, 8'd100, OP_ADD, 44, 1};
    vecs[2] = '{8'd40,  8'd15, OP_SUB, 25,  1};
    vecs[3] = '{8'd3,   8'd5,  OP_SUB, 254, 1};
    vecs[4] = '{8'd5,   8'd3,  OP_MUL, 15,  9};
    vecs[5] = '{8'd16,  8'd20, OP_MUL, 64,  9};
    vecs[6] = '{8'd20,  8'd4,  OP_DIV, 5,   9};
    vecs[7] = '{8'd7,   8'd2,  OP_DIV, 3,   9};
    vecs[8] = '{8'd9,   8'd0,  OP_DIV, 255, 1};
    vecs[9] = '{8'd255, 8'd1,  OP_DIV, 255, 9};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o", int'(o), 0);
    check("reset_ready", int'(ready), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, res);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_o", i), res, vecs[i].exp_o);
    end

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      logic [1:0] op;
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      op = 2'($urandom_range(0, 3));
      run_op(a, b, op, lat, res);
      check($sformatf("rnd%0d_lat a=%0d b=%0d op=%0d", i, a, b, op), lat, ref_lat(b, op));
      check($sformatf("rnd%0d_o a=%0d b=%0d op=%0d", i, a, b, op), res, ref_o(a, b, op));
    end

    // MUL with a stray request pulsed mid-BUSY.
    @(negedge clk);
    in_w  = {8'd5, 8'd3};
    op_w  = OP_MUL;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (ready) lat = i;
      @(negedge clk);
      valid = (i == 3);
      if (i == 3) begin
        in_w = {8'd100, 8'd100};
        op_w = OP_ADD;
      end
    end
    valid = 1'b0;
    check("busy_ignore_lat", lat, 9);
    check("busy_ignore_o", int'(o), 15);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_ready", i), int'(ready), 1);
      check($sformatf("hold%0d_o", i), int'(o), 15);
    end

    run_op(8'd30, 8'd12, OP_SUB, lat, res);
    check("after_hold_lat", lat, 1);
    check("after_hold_o", res, 18);

    // Reset during the fourth BUSY cycle of a divide.
    @(negedge clk);
    in_w  = {8'd20, 8'd4};
    op_w  = OP_DIV;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_o", int'(o), 0);
    check("midreset_ready", int'(ready), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midreset_no_result", int'(ready), 0);
    run_op(8'd1, 8'd1, OP_ADD, lat, res);
    check("post_reset_lat", lat, 1);
    check("post_reset_o", res, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
